// File: rtl/kiwi_directorate_supervisor.sv
// Host-side supervisor for the batch directorate nets of a KiwiC-generated DUT.
// Sequences DUT reset, arms on syndrome 8'hFF, and latches the termination result.
module kiwi_directorate_supervisor #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned ARM_TIMEOUT = 16,
    parameter int unsigned WDOG_CYCLES = 3000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_ack,
    input  logic [7:0]       i_dut_abend_syndrome,
    input  logic [7:0]       i_dut_unary_leds,
    output logic             o_dut_reset,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_status,
    output logic [7:0]       o_exit_code,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [7:0]       o_leds_snapshot
);

    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned ARM_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    localparam logic [7:0] SYN_RUNNING = 8'hFF;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_OK      = 3'd1;
    localparam logic [2:0] ST_ABEND   = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_ARMFAIL = 3'd4;
    localparam logic [2:0] ST_ABORTED = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [RST_W-1:0] r_rst_cnt;
    logic [ARM_W-1:0] r_arm_cnt;
    logic             r_dut_reset;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_status;
    logic [7:0]       r_exit_code;
    logic [CNT_W-1:0] r_cycle_count;
    logic [7:0]       r_leds_snapshot;

    state_t           w_state_nxt;
    logic [RST_W-1:0] w_rst_cnt_nxt;
    logic [ARM_W-1:0] w_arm_cnt_nxt;
    logic             w_dut_reset_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [2:0]       w_status_nxt;
    logic [7:0]       w_exit_code_nxt;
    logic [CNT_W-1:0] w_cycle_count_nxt;
    logic [7:0]       w_leds_snapshot_nxt;

    logic w_syn_running;
    logic w_rst_last;
    logic w_arm_last;
    logic w_wdog_last;

    assign w_syn_running = (i_dut_abend_syndrome == SYN_RUNNING);
    assign w_rst_last    = (r_rst_cnt == RST_W'(RST_CYCLES - 1));
    assign w_arm_last    = (r_arm_cnt == ARM_W'(ARM_TIMEOUT - 1));
    assign w_wdog_last   = (r_cycle_count == CNT_W'(WDOG_CYCLES - 1));

    // Next-state and result update; priority in RUN is abort, syndrome, watchdog.
    always_comb begin
        w_state_nxt         = r_state;
        w_rst_cnt_nxt       = r_rst_cnt;
        w_arm_cnt_nxt       = r_arm_cnt;
        w_dut_reset_nxt     = r_dut_reset;
        w_status_nxt        = r_status;
        w_exit_code_nxt     = r_exit_code;
        w_cycle_count_nxt   = r_cycle_count;
        w_leds_snapshot_nxt = r_leds_snapshot;

        unique case (r_state)
            S_IDLE: begin
                w_dut_reset_nxt = 1'b1;
                if (i_start) begin
                    w_status_nxt        = ST_NONE;
                    w_exit_code_nxt     = 8'h00;
                    w_cycle_count_nxt   = '0;
                    w_leds_snapshot_nxt = 8'h00;
                    w_rst_cnt_nxt       = '0;
                    w_state_nxt         = S_RESET;
                end
            end
            S_RESET: begin
                if (i_abort) begin
                    w_state_nxt         = S_DONE;
                    w_status_nxt        = ST_ABORTED;
                    w_dut_reset_nxt     = 1'b1;
                    w_leds_snapshot_nxt = i_dut_unary_leds;
                end else if (w_rst_last) begin
                    w_dut_reset_nxt = 1'b0;
                    w_arm_cnt_nxt   = '0;
                    w_state_nxt     = S_ARM;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
                end
            end
            S_ARM: begin
                if (i_abort) begin
                    w_state_nxt         = S_DONE;
                    w_status_nxt        = ST_ABORTED;
                    w_dut_reset_nxt     = 1'b1;
                    w_leds_snapshot_nxt = i_dut_unary_leds;
                end else if (w_syn_running) begin
                    w_cycle_count_nxt = '0;
                    w_state_nxt       = S_RUN;
                end else if (w_arm_last) begin
                    w_state_nxt     = S_DONE;
                    w_status_nxt    = ST_ARMFAIL;
                    w_dut_reset_nxt = 1'b1;
                end else begin
                    w_arm_cnt_nxt = r_arm_cnt + ARM_W'(1);
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt         = S_DONE;
                    w_status_nxt        = ST_ABORTED;
                    w_dut_reset_nxt     = 1'b1;
                    w_leds_snapshot_nxt = i_dut_unary_leds;
                end else if (!w_syn_running) begin
                    w_state_nxt         = S_DONE;
                    w_exit_code_nxt     = i_dut_abend_syndrome;
                    w_leds_snapshot_nxt = i_dut_unary_leds;
                    w_status_nxt        = (i_dut_abend_syndrome == 8'h00) ? ST_OK : ST_ABEND;
                end else if (w_wdog_last) begin
                    w_state_nxt         = S_DONE;
                    w_cycle_count_nxt   = CNT_W'(WDOG_CYCLES);
                    w_status_nxt        = ST_TIMEOUT;
                    w_dut_reset_nxt     = 1'b1;
                    w_leds_snapshot_nxt = i_dut_unary_leds;
                end else begin
                    w_cycle_count_nxt = r_cycle_count + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (i_ack) begin
                    w_state_nxt     = S_IDLE;
                    w_dut_reset_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_dut_reset_nxt = 1'b1;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_RESET) || (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_rst_cnt       <= '0;
            r_arm_cnt       <= '0;
            r_dut_reset     <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_status        <= ST_NONE;
            r_exit_code     <= 8'h00;
            r_cycle_count   <= '0;
            r_leds_snapshot <= 8'h00;
        end else begin
            r_state         <= w_state_nxt;
            r_rst_cnt       <= w_rst_cnt_nxt;
            r_arm_cnt       <= w_arm_cnt_nxt;
            r_dut_reset     <= w_dut_reset_nxt;
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
            r_status        <= w_status_nxt;
            r_exit_code     <= w_exit_code_nxt;
            r_cycle_count   <= w_cycle_count_nxt;
            r_leds_snapshot <= w_leds_snapshot_nxt;
        end
    end

    assign o_dut_reset     = r_dut_reset;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_status        = r_status;
    assign o_exit_code     = r_exit_code;
    assign o_cycle_count   = r_cycle_count;
    assign o_leds_snapshot = r_leds_snapshot;

endmodule
